mem_bus_arbiter: RTL and testbench

- Shares the single memory port (ADDR, DATA_OUT, DATA_IN, READ, WRITE) between two masters: M0 (processor) and M1 (DMA/IO engine).
- Each master issues one transaction at a time using a level REQ and a one-cycle DONE.
- Ties are resolved round-robin. Memory is modelled as fixed-latency, and the arbiter holds the bus stable for the full access.
- Sits between the processor top and the memory model.

---
 rtl/mem_bus_arbiter.sv | 117 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter giving two masters a shared fixed-latency memory port.
// The bus is held stable for the whole access, then DONE pulses to the owning master.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  RNW0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  output logic                  GNT0,
  output logic                  DONE0,
  input  logic                  REQ1,
  input  logic                  RNW1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  GNT1,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  READ,
  output logic                  WRITE
);
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
  state_t state_q, state_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic read_q, read_d, write_q, write_d, last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, rdata_q, rdata_d;
  logic pick1, rnw_sel;
  // M1 wins when it is the only requester, or on a tie when M0 was served last
  assign pick1 = REQ1 & (~REQ0 | ~last_q);
  assign rnw_sel = pick1 ? RNW1 : RNW0;
  always_comb begin
    state_d = state_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    read_d  = read_q;
    write_d = write_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (REQ0 | REQ1) begin
        addr_d  = pick1 ? ADDR1 : ADDR0;
        dout_d  = pick1 ? WDATA1 : WDATA0;
        read_d  = rnw_sel;
        write_d = ~rnw_sel;
        gnt0_d  = ~pick1;
        gnt1_d  = pick1;
        cnt_d   = 4'(MEM_LATENCY - 1);
        last_d  = pick1;
        state_d = ACCESS;
      end
      ACCESS: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        rdata_d = read_q ? DATA_IN : rdata_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = gnt0_q;
        done1_d = gnt1_q;
        state_d = COMPLETE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      read_q  <= read_d;
      write_q <= write_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end
  assign GNT0     = gnt0_q;
  assign GNT1     = gnt1_q;
  assign DONE0    = done0_q;
  assign DONE1    = done1_q;
  assign READ     = read_q;
  assign WRITE    = write_q;
  assign ADDR     = addr_q;
  assign DATA_OUT = dout_q;
  assign RDATA    = rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter with a transaction-level arbitration model.
module tb_mem_bus_arbiter;
  localparam int LAT = 2;
  logic CLK = 1'b0, RST = 1'b1;
  logic [1:0] req = '0, rnw = '0;
  logic [25:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0] gnt, done;
  logic [31:0] rdata, dout, din;
  logic [25:0] maddr;
  logic mread, mwrite;
  logic l_req = 1'b0;
  logic [25:0] l_ain = '0, l_addr;
  logic [1:0] l_gnt, l_done;
  logic [31:0] l_rdata, l_dout, l_din;
  logic l_read, l_write;
  int n_vec = 0, n_err = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_f(input logic [25:0] a);
    return (a == 26'h100) ? 32'hDEADBEEF : ({a, 6'b0} ^ 32'h5A5AA5A5);
  endfunction

  assign din = mem_f(maddr);
  assign l_din = mem_f(l_addr);

  mem_bus_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(req[0]), .RNW0(rnw[0]), .ADDR0(addr[0]), .WDATA0(wdata[0]), .GNT0(gnt[0]), .DONE0(done[0]),
    .REQ1(req[1]), .RNW1(rnw[1]), .ADDR1(addr[1]), .WDATA1(wdata[1]), .GNT1(gnt[1]), .DONE1(done[1]),
    .RDATA(rdata), .ADDR(maddr), .DATA_OUT(dout), .DATA_IN(din), .READ(mread), .WRITE(mwrite)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_l1 (
    .CLK(CLK), .RST(RST),
    .REQ0(l_req), .RNW0(1'b1), .ADDR0(l_ain), .WDATA0(32'h0), .GNT0(l_gnt[0]), .DONE0(l_done[0]),
    .REQ1(1'b0), .RNW1(1'b0), .ADDR1(26'h0), .WDATA1(32'h0), .GNT1(l_gnt[1]), .DONE1(l_done[1]),
    .RDATA(l_rdata), .ADDR(l_addr), .DATA_OUT(l_dout), .DATA_IN(l_din), .READ(l_read), .WRITE(l_write)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: a granted access occupies the bus until edge g+LAT+2; DONE appears after edge g+LAT
  typedef struct {
    int m;
    logic rnw;
    logic [25:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int dc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, free_at = 0;
  int last = 1;
  logic [31:0] rd_model = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      last = 1;
      free_at = 0;
      rd_model = '0;
    end else begin
      cyc++;
      if (cyc >= free_at && req != 2'b00) begin
        int m;
        exp_t e;
        m = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
        e.m = m;
        e.rnw = rnw[m];
        e.a = addr[m];
        e.wd = wdata[m];
        if (rnw[m]) rd_model = mem_f(addr[m]);
        e.rd = rd_model;
        e.dc = cyc + LAT;
        q.push_back(e);
        last = m;
        free_at = cyc + LAT + 2;
      end
    end
  end

  int strobes = 0;
  always @(negedge CLK) begin
    if (RST) strobes = 0;
    else begin
      chk("invariants", 64'({gnt == 2'b11, done == 2'b11, mread & mwrite, (|gnt) != (mread | mwrite)}), 64'd0);
      if (|gnt) begin
        if (q.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'd0);
        else begin
          chk("gnt_owner", 64'(gnt), 64'(q[0].m == 1 ? 2 : 1));
          chk("bus_addr", 64'(maddr), 64'(q[0].a));
          chk("bus_strobe", 64'({mread, mwrite}), 64'({q[0].rnw, ~q[0].rnw}));
          chk("bus_data_out", 64'(dout), 64'(q[0].wd));
          strobes++;
        end
      end
      if (|done) begin
        if (q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_owner", 64'(done), 64'(e.m == 1 ? 2 : 1));
          chk("done_cycle", 64'(cyc), 64'(e.dc));
          chk("strobe_cycles", 64'(strobes), 64'(LAT));
          chk("rdata", 64'(rdata), 64'(e.rd));
        end
        strobes = 0;
      end
    end
  end

  task automatic wait_done(output logic [1:0] d);
    d = 2'b00;
    for (int k = 0; k < 60 && d == 2'b00; k++) begin
      @(negedge CLK);
      d = done;
    end
    if (d == 2'b00) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_gnt(input int m);
    logic g;
    g = 1'b0;
    for (int k = 0; k < 60 && !g; k++) begin
      @(negedge CLK);
      g = gnt[m];
    end
    if (!g) chk("gnt_timeout", 64'd0, 64'd1);
  endtask

  int left[2], gap[2];
  bit busy[2];
  task automatic new_req(input int m);
    rnw[m] = 1'($urandom_range(1));
    addr[m] = 26'($urandom);
    wdata[m] = $urandom;
    req[m] = 1'b1;
    busy[m] = 1'b1;
    left[m]--;
  endtask

  initial begin
    logic [1:0] d;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (2) @(negedge CLK);
    chk("reset_ctl", 64'({gnt, done, mread, mwrite}), 64'd0);
    chk("reset_addr", 64'(maddr), 64'd0);
    chk("reset_dout", 64'(dout), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    #2 RST = 1'b0;
    @(negedge CLK);
    req[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 26'h100;
    wait_done(d);
    req[0] = 1'b0;
    chk("read_done0", 64'(d), 64'd1);
    chk("read_rdata", 64'(rdata), 64'hDEADBEEF);
    @(negedge CLK);
    req[1] = 1'b1; rnw[1] = 1'b0; addr[1] = 26'h200; wdata[1] = 32'h12345678;
    wait_done(d);
    req[1] = 1'b0;
    chk("write_done1", 64'(d), 64'd2);
    chk("write_rdata_kept", 64'(rdata), 64'hDEADBEEF);
    @(negedge CLK);
    req = 2'b11; rnw = 2'b01; addr[0] = 26'h10; addr[1] = 26'h20; wdata[0] = 32'hA; wdata[1] = 32'hB;
    for (int i = 0; i < 4; i++) begin
      wait_done(d);
      chk("rr_order", 64'(d), 64'(i % 2 == 0 ? 1 : 2));
      if (d[0]) addr[0] = addr[0] + 26'h4;
      if (d[1]) addr[1] = addr[1] + 26'h4;
    end
    req = 2'b00;
    @(negedge CLK);
    req[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 26'h100;
    wait_gnt(0);
    addr[0] = 26'h3FFFFFF; req[0] = 1'b0;
    wait_done(d);
    chk("drop_done0", 64'(d), 64'd1);
    repeat (4) @(negedge CLK);
    chk("drop_idle", 64'({gnt, done, mread, mwrite}), 64'd0);
    req[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 26'h40;
    wait_gnt(0);
    @(negedge CLK);
    #2 RST = 1'b1; req[0] = 1'b0;
    #1;
    chk("abort_ctl", 64'({gnt, done, mread, mwrite}), 64'd0);
    chk("abort_addr", 64'(maddr), 64'd0);
    chk("abort_rdata", 64'(rdata), 64'd0);
    repeat (2) @(negedge CLK);
    chk("abort_no_done", 64'(done), 64'd0);
    #2 RST = 1'b0;
    @(negedge CLK);
    req = 2'b11; rnw = 2'b11; addr[0] = 26'h44; addr[1] = 26'h88;
    wait_done(d);
    chk("tie_after_reset", 64'(d), 64'd1);
    req[0] = 1'b0;
    wait_done(d);
    req[1] = 1'b0;
    chk("tie_second", 64'(d), 64'd2);
    left = '{40, 40}; gap = '{0, 0}; busy = '{1'b0, 1'b0};
    for (int t = 0; t < 6000 && (left[0] > 0 || left[1] > 0 || busy[0] || busy[1]); t++) begin
      @(negedge CLK);
      for (int m = 0; m < 2; m++) begin
        if (busy[m] && done[m]) begin
          busy[m] = 1'b0;
          if (left[m] > 0 && $urandom_range(1) == 1) new_req(m);
          else begin
            req[m] = 1'b0;
            gap[m] = $urandom_range(3);
          end
        end else if (busy[m] && gnt[m]) begin
          rnw[m] = 1'($urandom_range(1));
          addr[m] = 26'($urandom);
          wdata[m] = $urandom;
        end else if (!busy[m] && left[m] > 0) begin
          if (gap[m] > 0) gap[m]--;
          else new_req(m);
        end
      end
    end
    chk("random_finished", 64'({busy[1], busy[0]}), 64'd0);
    req = 2'b00;
    @(negedge CLK);
    l_req = 1'b1; l_ain = 26'h123;
    @(negedge CLK);
    chk("l1_strobe", 64'({l_read, l_gnt}), 64'b101);
    l_req = 1'b0;
    @(negedge CLK);
    chk("l1_done", 64'({l_read, l_done}), 64'b001);
    chk("l1_rdata", 64'(l_rdata), 64'(mem_f(26'h123)));
    @(negedge CLK);
    chk("l1_done_end", 64'(l_done), 64'd0);
    repeat (10) @(negedge CLK);
    chk("drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
